// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-path definitions: zigzag table, FSM state codes and the
// symbol-kind encoding reused by the downstream Huffman stage.
package jpeg_pkg;

    localparam int COEF_W_DEF = 8;
    localparam int RUN_W_DEF  = 4;
    localparam int NUM_COEF   = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_DC   = 3'd1;
    localparam state_t ST_SCAN = 3'd2;
    localparam state_t ST_ZRL  = 3'd3;
    localparam state_t ST_AC   = 3'd4;
    localparam state_t ST_EOB  = 3'd5;
    localparam state_t ST_DONE = 3'd6;

    typedef enum logic [1:0] {
        SYM_DC  = 2'd0,
        SYM_AC  = 2'd1,
        SYM_ZRL = 2'd2,
        SYM_EOB = 2'd3
    } sym_kind_e;

    // Raster index of the coefficient at each zigzag position.
    localparam logic [5:0] ZIGZAG [NUM_COEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zigzag_coef_buffer.sv
// Holds one latched 8x8 coefficient block and reads it back in zigzag order.
module zigzag_coef_buffer
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [COEF_W*NUM_COEF-1:0] coeffs,
    input  logic [5:0]                 idx,
    output logic signed [COEF_W-1:0]   coef
);

    logic signed [COEF_W-1:0] mem [NUM_COEF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_COEF; k++) mem[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_COEF; k++) mem[k] <= coeffs[COEF_W*k +: COEF_W];
        end
    end

    assign coef = mem[ZIGZAG[idx]];

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Zigzag run-length encoder: turns a quantized 8x8 block into DC / AC / ZRL /
// EOB symbols over a valid/ready stream with fully registered output fields.
module zigzag_rle_encoder
    import jpeg_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int RUN_W  = RUN_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [COEF_W*NUM_COEF-1:0] coeffs,
    output logic                       busy,
    output logic                       start_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RUN_W-1:0]           out_run,
    output logic signed [COEF_W-1:0]   out_value,
    output logic                       out_is_dc,
    output logic                       out_zrl,
    output logic                       out_eob,
    output logic                       block_done
);

    localparam logic [5:0] ZRL_STEP = 6'(1 << RUN_W);

    state_t                   state, state_n;
    logic [5:0]               idx, idx_n;
    logic [5:0]               zrun, zrun_n;
    logic signed [COEF_W-1:0] ac_val, ac_val_n;
    logic signed [COEF_W-1:0] coef_zz;
    logic                     load;
    logic                     transfer;

    sym_kind_e                kind_n;
    logic                     valid_n;
    logic [RUN_W-1:0]         run_n;
    logic signed [COEF_W-1:0] value_n;

    assign load     = start && (state == ST_IDLE);
    assign transfer = out_valid && out_ready;

    zigzag_coef_buffer #(.COEF_W(COEF_W)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .coeffs (coeffs),
        .idx    (idx),
        .coef   (coef_zz)
    );

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        zrun_n   = zrun;
        ac_val_n = ac_val;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_DC;
                    idx_n   = '0;
                    zrun_n  = '0;
                end
            end
            ST_DC: begin
                if (transfer) begin
                    idx_n   = 6'd1;
                    zrun_n  = '0;
                    state_n = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (coef_zz == '0) begin
                    if (idx != 6'd63) begin
                        zrun_n = zrun + 6'd1;
                        idx_n  = idx + 6'd1;
                    end else begin
                        state_n = ST_EOB;
                    end
                end else begin
                    ac_val_n = coef_zz;
                    state_n  = (zrun >= ZRL_STEP) ? ST_ZRL : ST_AC;
                end
            end
            ST_ZRL: begin
                if (transfer) begin
                    zrun_n = zrun - ZRL_STEP;
                    if (zrun_n < ZRL_STEP) state_n = ST_AC;
                end
            end
            ST_AC: begin
                if (transfer) begin
                    zrun_n = '0;
                    if (idx == 6'd63) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n   = idx + 6'd1;
                        state_n = ST_SCAN;
                    end
                end
            end
            ST_EOB: begin
                if (transfer) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output fields are computed from the next state so they can be registered;
    // an unchanged state with no transfer reproduces the same fields.
    always_comb begin
        valid_n = 1'b0;
        kind_n  = SYM_AC;
        run_n   = '0;
        value_n = '0;
        case (state_n)
            ST_DC: begin
                valid_n = 1'b1;
                kind_n  = SYM_DC;
                value_n = (state == ST_IDLE) ? coeffs[COEF_W-1:0] : out_value;
            end
            ST_ZRL: begin
                valid_n = 1'b1;
                kind_n  = SYM_ZRL;
                run_n   = '1;
            end
            ST_AC: begin
                valid_n = 1'b1;
                kind_n  = SYM_AC;
                run_n   = zrun_n[RUN_W-1:0];
                value_n = ac_val_n;
            end
            ST_EOB: begin
                valid_n = 1'b1;
                kind_n  = SYM_EOB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            zrun       <= '0;
            ac_val     <= '0;
            busy       <= 1'b0;
            start_err  <= 1'b0;
            out_valid  <= 1'b0;
            out_run    <= '0;
            out_value  <= '0;
            out_is_dc  <= 1'b0;
            out_zrl    <= 1'b0;
            out_eob    <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            zrun       <= zrun_n;
            ac_val     <= ac_val_n;
            busy       <= (state_n != ST_IDLE);
            start_err  <= start && (state != ST_IDLE);
            out_valid  <= valid_n;
            out_run    <= run_n;
            out_value  <= value_n;
            out_is_dc  <= valid_n && (kind_n == SYM_DC);
            out_zrl    <= valid_n && (kind_n == SYM_ZRL);
            out_eob    <= valid_n && (kind_n == SYM_EOB);
            block_done <= (state_n == ST_DONE);
        end
    end

endmodule
